rr_mux_arb: RTL and testbench



---
 rtl/rr_mux_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rr_mux_arb.sv | 97 +++++++++
 tb/tb_rr_mux_arb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select mux arbiter.
// The saturating counter helper is used only when RR_MUX_ARB_STATS_EN is defined.
package rr_mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   CNT_W      = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: searches ptr+1, ptr+2, ... mod N.
// No state; the pointer is owned by the parent. Grant is all-zero when en is low.
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    if (en) begin
      for (int i = 1; i <= N; i++) begin
        k = (int'(ptr) + i) % N;
        if (!found && req[k]) begin
          found   = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready selector, fixed-select or round-robin, one registered output stage (1 cycle, full rate).
// Stalls all inputs while the output beat is held unaccepted; RR_MUX_ARB_STATS_EN adds a handshake counter.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  output logic [N-1:0]       in_ready_o,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               mode_i,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_ch_o,
  input  logic               out_ready_i
`ifdef RR_MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   xfer_cnt_o
`endif
);

  logic [SEL_W-1:0] ptr;
  logic             can_load;
  logic [N-1:0]     fixed_req;
  logic [N-1:0]     arb_req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;
  logic [WIDTH-1:0] gnt_dat;

  assign can_load = !out_valid_o || out_ready_i;

  // Fixed mode presents at most one request, so the rotating search simply finds it;
  // a sel_i outside 0..N-1 matches no channel and yields no grant.
  always_comb begin
    fixed_req = '0;
    for (int k = 0; k < N; k++) begin
      fixed_req[k] = in_valid_i[k] && (sel_i == SEL_W'(k));
    end
  end

  assign arb_req = (mode_i == MODE_RR) ? in_valid_i : fixed_req;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (arb_req),
    .ptr     (ptr),
    .en      (can_load && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are only issued to valid channels, so any grant is a transfer.
  assign in_ready_o = gnt;
  assign xfer       = |gnt;

  always_comb begin
    gnt_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) gnt_dat = in_data_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      ptr         <= SEL_W'(N-1);
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= gnt_dat;
      out_ch_o    <= gnt_idx;
      if (mode_i == MODE_RR) ptr <= gnt_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef RR_MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i) begin
      xfer_cnt_o <= sat_inc(xfer_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed table-driven bench for rr_mux_arb (N=4, WIDTH=8) plus a short hand-written sequence.
module tb_rr_mux_arb;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;

  logic               clk;
  logic               reset;
  logic [N-1:0]       in_valid_i;
  logic [N*WIDTH-1:0] in_data_i;
  logic [N-1:0]       in_ready_o;
  logic [SEL_W-1:0]   sel_i;
  logic               mode_i;
  logic               out_valid_o;
  logic [WIDTH-1:0]   out_data_o;
  logic [SEL_W-1:0]   out_ch_o;
  logic               out_ready_i;
`ifdef RR_MUX_ARB_STATS_EN
  logic [15:0]        xfer_cnt_o;
`endif

  rr_mux_arb #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .sel_i       (sel_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .out_ready_i (out_ready_i)
`ifdef RR_MUX_ARB_STATS_EN
    ,
    .xfer_cnt_o  (xfer_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [1:0]  sel;
    logic        mode;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_och;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [31:0] dat,
                              input logic [1:0] sel, input logic mode, input logic ordy,
                              input logic [3:0] e_rdy, input logic e_ov, input logic [7:0] e_od,
                              input logic [1:0] e_och, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.sel = sel; v.mode = mode; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_och = e_och; v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam logic [31:0] D0 = 32'h13121110;
  localparam logic [31:0] DA = 32'h13A51110;

  initial begin
    // reset held two cycles with every channel valid
    vecs[0]  = mk(1, 4'b1111, D0, 0, 1, 1, 4'b0000, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 4'b1111, D0, 0, 1, 1, 4'b0000, 0, 8'h00, 0, 0);
    // round-robin fairness: ch0,1,2,3,0
    vecs[2]  = mk(0, 4'b1111, D0, 0, 1, 1, 4'b0001, 1, 8'h10, 0, 0);
    vecs[3]  = mk(0, 4'b1111, D0, 0, 1, 1, 4'b0010, 1, 8'h11, 1, 1);
    vecs[4]  = mk(0, 4'b1111, D0, 0, 1, 1, 4'b0100, 1, 8'h12, 2, 2);
    vecs[5]  = mk(0, 4'b1111, D0, 0, 1, 1, 4'b1000, 1, 8'h13, 3, 3);
    vecs[6]  = mk(0, 4'b1111, D0, 0, 1, 1, 4'b0001, 1, 8'h10, 0, 4);
    // skip and wrap
    vecs[7]  = mk(0, 4'b1001, D0, 0, 1, 1, 4'b1000, 1, 8'h13, 3, 5);
    vecs[8]  = mk(0, 4'b1001, D0, 0, 1, 1, 4'b0001, 1, 8'h10, 0, 6);
    // fixed select, then select of an invalid channel
    vecs[9]  = mk(0, 4'b0100, DA, 2, 0, 1, 4'b0100, 1, 8'hA5, 2, 7);
    vecs[10] = mk(0, 4'b0100, DA, 1, 0, 1, 4'b0000, 0, 8'hA5, 2, 8);
    vecs[11] = mk(0, 4'b0100, DA, 1, 0, 1, 4'b0000, 0, 8'hA5, 2, 8);
    // RR resumes after ptr=0 (fixed grant left ptr alone), then 3-cycle stall and release
    vecs[12] = mk(0, 4'b1111, D0, 1, 1, 1, 4'b0010, 1, 8'h11, 1, 8);
    vecs[13] = mk(0, 4'b1111, D0, 1, 1, 0, 4'b0000, 1, 8'h11, 1, 8);
    vecs[14] = mk(0, 4'b1111, D0, 1, 1, 0, 4'b0000, 1, 8'h11, 1, 8);
    vecs[15] = mk(0, 4'b1111, D0, 1, 1, 0, 4'b0000, 1, 8'h11, 1, 8);
    vecs[16] = mk(0, 4'b1111, D0, 1, 1, 1, 4'b0100, 1, 8'h12, 2, 9);
    // mid-stream reset drops the held beat and restarts priority at ch0
    vecs[17] = mk(1, 4'b1111, D0, 1, 1, 0, 4'b0000, 0, 8'h00, 0, 0);
    vecs[18] = mk(0, 4'b1111, D0, 1, 1, 1, 4'b0001, 1, 8'h10, 0, 0);
    vecs[19] = mk(0, 4'b0000, D0, 1, 1, 1, 4'b0000, 0, 8'h10, 0, 1);
    // fixed grant of ch3 does not move ptr; RR then picks ch1; mode change during stall
    vecs[20] = mk(0, 4'b1111, D0, 3, 0, 1, 4'b1000, 1, 8'h13, 3, 1);
    vecs[21] = mk(0, 4'b1111, D0, 3, 1, 1, 4'b0010, 1, 8'h11, 1, 2);
    vecs[22] = mk(0, 4'b0001, D0, 0, 0, 0, 4'b0000, 1, 8'h11, 1, 2);

    reset       = 1'b1;
    in_valid_i  = '0;
    in_data_i   = '0;
    sel_i       = '0;
    mode_i      = 1'b1;
    out_ready_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      in_valid_i  = vecs[i].vld;
      in_data_i   = vecs[i].dat;
      sel_i       = vecs[i].sel;
      mode_i      = vecs[i].mode;
      out_ready_i = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready_o), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data_o), 32'(vecs[i].e_od));
      check($sformatf("v%0d out_ch", i), 32'(out_ch_o), 32'(vecs[i].e_och));
`ifdef RR_MUX_ARB_STATS_EN
      check($sformatf("v%0d xfer_cnt", i), 32'(xfer_cnt_o), 32'(vecs[i].e_cnt));
`endif
    end

    // Drain the held beat: out_valid falls, data/ch hold.
    @(negedge clk);
    in_valid_i  = 4'b0000;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("drain out_valid", 32'(out_valid_o), 32'd0);
    check("drain out_ch", 32'(out_ch_o), 32'd1);

    // in_valid must not reach out_valid combinationally; in_ready must not follow in_data.
    @(negedge clk);
    mode_i     = 1'b1;
    in_valid_i = 4'b0100;
    #1;
    check("no comb valid path", 32'(out_valid_o), 32'd0);
    check("ready ch2", 32'(in_ready_o), 32'b0100);
    in_data_i = 32'hFFFF_FFFF;
    #1;
    check("ready vs data", 32'(in_ready_o), 32'b0100);
    @(posedge clk);
    #1;
    check("load after data change", 32'(out_data_o), 32'hFF);
    check("load ch2", 32'(out_ch_o), 32'd2);
    check("load valid", 32'(out_valid_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
